// File: rtl/oxi_pkg.sv
// rtl/oxi_pkg.sv - shared sequencer state/channel types and sample width for the oximeter datapath
package oxi_pkg;

    localparam int ADC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD,
        ST_SETTLE,
        ST_CONV,
        ST_HOLD
    } seq_state_e;

    typedef enum logic {
        CH_RED = 1'b0,
        CH_IR  = 1'b1
    } chan_e;

endpackage

// File: rtl/led_adc_sequencer_phase_timer.sv
// rtl/led_adc_sequencer_phase_timer.sv - wrapping per-phase cycle counter with dead/settle/phase-end decodes
module phase_timer #(
    parameter int PHASE_CYCLES  = 5000,
    parameter int DEAD_CYCLES   = 50,
    parameter int SETTLE_CYCLES = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic dead_end_o,
    output logic settle_end_o,
    output logic phase_end_o
);

    localparam int CNT_W = $clog2(PHASE_CYCLES);

    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;

    assign dead_end_o   = run_i && (phase_cnt_q == CNT_W'(DEAD_CYCLES - 1));
    assign settle_end_o = run_i && (phase_cnt_q == CNT_W'(DEAD_CYCLES + SETTLE_CYCLES - 1));
    assign phase_end_o  = run_i && (phase_cnt_q == CNT_W'(PHASE_CYCLES - 1));

    // Held at zero while idle so the first running cycle is phase cycle 0.
    always_comb begin
        phase_cnt_d = '0;
        if (run_i && !phase_end_o) begin
            phase_cnt_d = phase_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_cnt_q <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
        end
    end

endmodule

// File: rtl/led_adc_sequencer.sv
// rtl/led_adc_sequencer.sv - red/IR LED alternation and ADC sequencing with per-channel sample strobes
// LED_SEQ_AVG2_EN: two conversions per phase, averaged result strobed once.
module led_adc_sequencer
    import oxi_pkg::*;
#(
    parameter int PHASE_CYCLES  = 5000,
    parameter int DEAD_CYCLES   = 50,
    parameter int SETTLE_CYCLES = 500
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             red_valid,
    output logic             ir_valid,
    output logic             adc_timeout
);

    seq_state_e       state_q, state_d;
    chan_e            chan_q, chan_d;
    logic             led_red_q, led_red_d;
    logic             led_ir_q, led_ir_d;
    logic             start_q, start_d;
    logic [ADC_W-1:0] red_val_q, red_val_d;
    logic [ADC_W-1:0] ir_val_q, ir_val_d;
    logic             red_vld_q, red_vld_d;
    logic             ir_vld_q, ir_vld_d;
    logic             tmo_q, tmo_d;
    logic             accept;
    logic [ADC_W-1:0] result;
    logic             dead_end, settle_end, phase_end;

    phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_phase_timer (
        .clk_i       (CLK),
        .rst_ni      (rst_n),
        .run_i       (state_q != ST_IDLE),
        .dead_end_o  (dead_end),
        .settle_end_o(settle_end),
        .phase_end_o (phase_end)
    );

`ifdef LED_SEQ_AVG2_EN
    logic             first_q, first_d;
    logic [ADC_W-1:0] samp_a_q, samp_a_d;

    assign result = ADC_W'(((ADC_W+1)'(samp_a_q) + (ADC_W+1)'(adc_data)) >> 1);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= 1'b0;
            samp_a_q <= '0;
        end else begin
            first_q  <= first_d;
            samp_a_q <= samp_a_d;
        end
    end
`else
    assign result = adc_data;
`endif

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        red_val_d = red_val_q;
        ir_val_d  = ir_val_q;
        start_d   = 1'b0;
        red_vld_d = 1'b0;
        ir_vld_d  = 1'b0;
        tmo_d     = 1'b0;
        accept    = 1'b0;
`ifdef LED_SEQ_AVG2_EN
        first_d   = first_q;
        samp_a_d  = samp_a_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                chan_d = CH_RED;
                if (enable) state_d = ST_DEAD;
            end
            ST_DEAD: begin
                if (dead_end) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_end) begin
                    state_d = ST_CONV;
                    start_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (adc_done) begin
`ifdef LED_SEQ_AVG2_EN
                    if (first_q) begin
                        accept  = 1'b1;
                        first_d = 1'b0;
                    end else begin
                        samp_a_d = adc_data;
                        first_d  = 1'b1;
                        start_d  = !phase_end;
                    end
`else
                    accept = 1'b1;
`endif
                end
            end
            ST_HOLD: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_HOLD;
            if (chan_q == CH_RED) begin
                red_val_d = result;
                red_vld_d = 1'b1;
            end else begin
                ir_val_d = result;
                ir_vld_d = 1'b1;
            end
        end

        // Phase end overrides everything except a result accepted on this same cycle.
        if (phase_end) begin
            tmo_d   = (state_q == ST_CONV) && !accept;
            start_d = 1'b0;
            state_d = enable ? ST_DEAD : ST_IDLE;
            chan_d  = !enable ? CH_RED : ((chan_q == CH_RED) ? CH_IR : CH_RED);
`ifdef LED_SEQ_AVG2_EN
            first_d = 1'b0;
`endif
        end

        led_red_d = (state_d inside {ST_SETTLE, ST_CONV, ST_HOLD}) && (chan_d == CH_RED);
        led_ir_d  = (state_d inside {ST_SETTLE, ST_CONV, ST_HOLD}) && (chan_d == CH_IR);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            chan_q    <= CH_RED;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            start_q   <= 1'b0;
            red_val_q <= '0;
            ir_val_q  <= '0;
            red_vld_q <= 1'b0;
            ir_vld_q  <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            led_red_q <= led_red_d;
            led_ir_q  <= led_ir_d;
            start_q   <= start_d;
            red_val_q <= red_val_d;
            ir_val_q  <= ir_val_d;
            red_vld_q <= red_vld_d;
            ir_vld_q  <= ir_vld_d;
            tmo_q     <= tmo_d;
        end
    end

    assign adc_start     = start_q;
    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign RED_ADC_Value = red_val_q;
    assign IR_ADC_Value  = ir_val_q;
    assign red_valid     = red_vld_q;
    assign ir_valid      = ir_vld_q;
    assign adc_timeout   = tmo_q;

endmodule

// File: doc/led_adc_sequencer.md
# led_adc_sequencer

Drives the finger-clip LEDs, alternating red and infrared at 100 Hz, and sequences the external 8-bit ADC so that each conversion is attributed to the LED that was lit. It is the producer side of the filter datapath: it delivers `RED_ADC_Value` and `IR_ADC_Value`, each with a one-cycle valid strobe, to the red and IR FIR filters. It sits between the ADC/LED pads and the filter bank.

## Interface
Parameters:
- `PHASE_CYCLES`, default 5000: clock cycles per LED phase. At 1 MHz this is 5 ms, giving a 10 ms red+IR period.
- `DEAD_CYCLES`, default 50: cycles at the start of each phase with both LEDs off.
- `SETTLE_CYCLES`, default 500: cycles from LED on to `adc_start`.
- Legal values: `DEAD_CYCLES` ≥ 1, and `DEAD_CYCLES + SETTLE_CYCLES` < `PHASE_CYCLES - 1`.

Ports:
- `CLK` input 1: system clock; single clock domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: run request.
- `adc_start` output 1: one-cycle conversion request.
- `adc_done` input 1: one-cycle conversion-complete pulse.
- `adc_data` input 8: conversion result, valid while `adc_done` is high.
- `LED_RED` output 1: red LED drive.
- `LED_IR` output 1: infrared LED drive.
- `RED_ADC_Value` output 8: last accepted red sample.
- `IR_ADC_Value` output 8: last accepted IR sample.
- `red_valid` output 1: one-cycle strobe, `RED_ADC_Value` updated.
- `ir_valid` output 1: one-cycle strobe, `IR_ADC_Value` updated.
- `adc_timeout` output 1: one-cycle pulse when a phase ends with no conversion result.

## Operation
- **States:** IDLE, DEAD, SETTLE, CONV, HOLD. A `chan` register selects the channel: 0 = red, 1 = IR.
- **Phase counter:** `phase_cnt` counts 0..`PHASE_CYCLES-1` and wraps to 0 at the end of each phase. On wrap, `chan` toggles.
- **IDLE:**
  - Both LEDs off, `chan` = red.
  - If `enable` = 1, go to DEAD with `phase_cnt` = 0.
- **DEAD:** LEDs off. When `phase_cnt` = `DEAD_CYCLES-1`, go to SETTLE.
- **SETTLE:**
  - The selected LED is on.
  - When `phase_cnt` = `DEAD_CYCLES+SETTLE_CYCLES-1`, go to CONV and assert `adc_start` for the next single cycle.
- **CONV:**
  - Selected LED stays on.
  - On `adc_done`, latch `adc_data` into the selected channel's value register, pulse that channel's valid strobe, and go to HOLD.
- **HOLD:** Selected LED stays on until the phase ends.
- **Phase end** (`phase_cnt` = `PHASE_CYCLES-1`):
  - If `enable` = 0, go to IDLE.
  - Otherwise go to DEAD with the other channel.
  - If the state was CONV with no `adc_done`, pulse `adc_timeout`. No strobe is issued and the value register is unchanged.
- **Invariants:**
  - `LED_RED` and `LED_IR` are never high together.
  - Every LED transition passes through at least `DEAD_CYCLES` with both LEDs off.
- **Edge cases:**
  - `adc_done` outside CONV is ignored.
  - `adc_done` on the phase-end cycle while in CONV is accepted: strobe, no timeout.
  - Deasserting `enable` mid-phase completes the current phase, including its conversion.
- **Reset** (asserted at any time, including mid-conversion): all outputs 0, value registers 0, state IDLE, `chan` = red. A pending `adc_done` after release is ignored.

## Timing
- LEDs and `adc_start` are registered outputs, glitch-free.
- Taking cycle 0 as the first DEAD cycle:
  - LED on at cycle `DEAD_CYCLES`.
  - `adc_start` high at cycle `DEAD_CYCLES+SETTLE_CYCLES`.
- Latency from `adc_done` sampled high to value register and strobe visible: 1 cycle.
- One sample per channel per 2×`PHASE_CYCLES`. Red and IR strobes are never simultaneous.
- `adc_timeout` is visible the cycle after the phase-end cycle, coincident with the new DEAD.

## Configuration
- **`LED_SEQ_AVG2_EN` defined:**
  - Each phase performs two conversions. The second `adc_start` is issued the cycle after the first `adc_done`.
  - The output is `(a+b)>>1` (9-bit sum, truncated), strobed once after the second `adc_done`.
  - A timeout after only one result discards that result.
- **`LED_SEQ_AVG2_EN` undefined:** one conversion per phase, data passed through unmodified.

## Structure
- **Shared package** (`oxi_pkg`):
  - State enum (IDLE/DEAD/SETTLE/CONV/HOLD).
  - Channel enum (RED/IR).
  - Sample width constant `ADC_W` = 8, which the FIR filters also use.
- **Sub-module:** `phase_timer` is natural. It holds the wrapping `phase_cnt` and issues decode pulses `dead_end`, `settle_end` and `phase_end`. The FSM and datapath stay in the top module.

## Test plan
All scenarios use `PHASE_CYCLES`=20, `DEAD_CYCLES`=2, `SETTLE_CYCLES`=4.
- **Normal red phase:** enable, ADC model answers 3 cycles after `adc_start` with 0xA5.
  - `LED_RED` high on phase cycles 2..19, `adc_start` on cycle 6.
  - `RED_ADC_Value`=0xA5 with `red_valid` on cycle 10.
  - Next phase: `LED_IR` high on cycles 2..19 with `LED_RED` low throughout.
- **Timeout:** ADC never answers in the IR phase.
  - `adc_timeout` pulses once at the next phase start.
  - `IR_ADC_Value` keeps its prior value and `ir_valid` never fires.
- **Done on last cycle:** `adc_done` with 0x3C on phase cycle 19.
  - Value accepted, strobe asserted, no timeout.
- **Stray done:** `adc_done` pulses during DEAD/SETTLE/HOLD.
  - No register or strobe change.
- **Enable and reset:**
  - Drop `enable` mid-phase: the phase finishes, then IDLE with both LEDs off.
  - Assert `rst_n`=0 during CONV: all outputs 0 immediately.
  - After release with `enable`=1: restarts on the red channel.
- **With `LED_SEQ_AVG2_EN`:** ADC samples 0x10 then 0x13.
  - Single strobe with value 0x11.
  - The second `adc_start` comes 1 cycle after the first `adc_done`.
